// File: rtl/display_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_cmd_pkg
//  Description : Shared definitions for the display command path:
//                command opcodes, decoder states and enable reset values.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_cmd_pkg;

  // Command opcodes, all ASCII letters
  localparam logic [7:0] OP_BRIGHT  = 8'h62;  // 'b'
  localparam logic [7:0] OP_RGB     = 8'h63;  // 'c'
  localparam logic [7:0] OP_LINE    = 8'h4C;  // 'L'
  localparam logic [7:0] OP_FILL    = 8'h46;  // 'F'
  localparam logic [7:0] OP_RESTORE = 8'h52;  // 'R'

  // Decoder states
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARG_BRIGHT = 3'd1,
    ST_ARG_RGB    = 3'd2,
    ST_ROW_SEL    = 3'd3,
    ST_ROW_DATA   = 3'd4,
    ST_FILL_VAL   = 3'd5,
    ST_FILLING    = 3'd6
  } state_e;

  // Reset values of the global enables; brightness is sliced to its width
  localparam logic [2:0] RGB_RESET    = 3'b111;
  localparam logic [7:0] BRIGHT_RESET = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/cmd_timeout_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cmd_timeout_counter
//  Description : Inter-byte idle counter. Cleared by each received byte or
//                when disabled; pulses expired_o on the cycle whose edge
//                would bring the count to TICKS.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmd_timeout_counter #(
  parameter int TICKS = 2000,
  parameter int WIDTH = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(TICKS - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Next count: restart on a byte or when idle, otherwise count up
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || !enable_i) cnt_d = '0;
  end

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A byte arriving in the terminal cycle wins over the timeout
  assign expired_o = enable_i && !clear_i && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/display_command_engine.sv
`default_nettype none
// ============================================================================
//  Module      : display_command_engine
//  Description : Decodes the UART byte stream into display commands:
//                brightness / colour enables, row writes and RAM fill into
//                the frame RAM, with inter-byte timeout and error pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_command_engine #(
  parameter int ROW_BYTES_LOG2   = 6,
  parameter int ROW_ADDR_WIDTH   = 4,
  parameter int BRIGHTNESS_WIDTH = 6,
  parameter int TIMEOUT_TICKS    = 2000,
  parameter int TIMEOUT_WIDTH    = 11
) (
  input  logic                                     clk_in,
  input  logic                                     reset,
  input  logic [7:0]                               rx_data,
  input  logic                                     rx_valid,
  output logic [2:0]                               rgb_enable,
  output logic [BRIGHTNESS_WIDTH-1:0]              brightness_enable,
  output logic [7:0]                               ram_data_out,
  output logic [ROW_ADDR_WIDTH+ROW_BYTES_LOG2-1:0] ram_address,
  output logic                                     ram_write_enable,
  output logic                                     busy,
  output logic                                     cmd_error,
  output logic [7:0]                               num_commands_processed
);

  import display_cmd_pkg::*;

  // Derived from the row geometry so the fill always covers every row
  localparam int RAM_ADDR_WIDTH = ROW_ADDR_WIDTH + ROW_BYTES_LOG2;
  localparam logic [BRIGHTNESS_WIDTH-1:0] C_BRIGHT_RST = BRIGHT_RESET[BRIGHTNESS_WIDTH-1:0];

  state_e                        state_q, state_d;
  logic [2:0]                    rgb_q, rgb_d;
  logic [BRIGHTNESS_WIDTH-1:0]   bright_q, bright_d;
  logic [ROW_ADDR_WIDTH-1:0]     row_q, row_d;
  logic [ROW_BYTES_LOG2-1:0]     idx_q, idx_d;
  logic [7:0]                    fill_val_q, fill_val_d;
  logic [RAM_ADDR_WIDTH-1:0]     fill_addr_q, fill_addr_d;
  logic [7:0]                    wdata_q, wdata_d;
  logic [RAM_ADDR_WIDTH-1:0]     waddr_q, waddr_d;
  logic                          we_q, we_d;
  logic                          err_q, err_d;
  logic [7:0]                    count_q, count_d;
  logic                          w_timeout_active;
  logic                          w_timeout;

  // Timeout runs only while waiting for bytes of an open command
  assign w_timeout_active = (state_q != ST_IDLE) && (state_q != ST_FILLING);

  cmd_timeout_counter #(
    .TICKS (TIMEOUT_TICKS),
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk_i     (clk_in),
    .rst_i     (reset),
    .clear_i   (rx_valid),
    .enable_i  (w_timeout_active),
    .expired_o (w_timeout)
  );

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode; a timeout aborts any open command
  always_comb begin
    state_d = state_q;
    if (w_timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          case (rx_data)
            OP_BRIGHT: state_d = ST_ARG_BRIGHT;
            OP_RGB:    state_d = ST_ARG_RGB;
            OP_LINE:   state_d = ST_ROW_SEL;
            OP_FILL:   state_d = ST_FILL_VAL;
            default:   state_d = ST_IDLE;
          endcase
        end
        ST_ARG_BRIGHT, ST_ARG_RGB: if (rx_valid) state_d = ST_IDLE;
        ST_ROW_SEL:  if (rx_valid) state_d = ST_ROW_DATA;
        ST_ROW_DATA: if (rx_valid && (&idx_q)) state_d = ST_IDLE;
        ST_FILL_VAL: if (rx_valid) state_d = ST_FILLING;
        ST_FILLING:  if (&fill_addr_q) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output decode per state
  always_comb begin
    rgb_d       = rgb_q;
    bright_d    = bright_q;
    row_d       = row_q;
    idx_d       = idx_q;
    fill_val_d  = fill_val_q;
    fill_addr_d = fill_addr_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    count_d     = count_q;
    we_d        = 1'b0;
    err_d       = 1'b0;
    if (w_timeout) begin
      err_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: if (rx_valid) begin
          case (rx_data)
            OP_BRIGHT, OP_RGB, OP_LINE, OP_FILL: ;
            OP_RESTORE: begin
              rgb_d    = RGB_RESET;
              bright_d = C_BRIGHT_RST;
              count_d  = count_q + 8'd1;
            end
            default: err_d = 1'b1;
          endcase
        end
        ST_ARG_BRIGHT: if (rx_valid) begin
          bright_d = rx_data[BRIGHTNESS_WIDTH-1:0];
          count_d  = count_q + 8'd1;
        end
        ST_ARG_RGB: if (rx_valid) begin
          rgb_d   = rx_data[2:0];
          count_d = count_q + 8'd1;
        end
        ST_ROW_SEL: if (rx_valid) begin
          row_d = rx_data[ROW_ADDR_WIDTH-1:0];
          idx_d = '0;
        end
        ST_ROW_DATA: if (rx_valid) begin
          we_d    = 1'b1;
          waddr_d = {row_q, idx_q};
          wdata_d = rx_data;
          idx_d   = idx_q + 1'b1;
          if (&idx_q) count_d = count_q + 8'd1;
        end
        ST_FILL_VAL: if (rx_valid) begin
          fill_val_d  = rx_data;
          fill_addr_d = '0;
        end
        ST_FILLING: begin
          // Address counter wraps to zero on the final write
          we_d        = 1'b1;
          waddr_d     = fill_addr_q;
          wdata_d     = fill_val_q;
          fill_addr_d = fill_addr_q + 1'b1;
          if (&fill_addr_q) count_d = count_q + 8'd1;
          if (rx_valid)     err_d   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered output stage
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rgb_q       <= RGB_RESET;
      bright_q    <= C_BRIGHT_RST;
      row_q       <= '0;
      idx_q       <= '0;
      fill_val_q  <= '0;
      fill_addr_q <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      rgb_q       <= rgb_d;
      bright_q    <= bright_d;
      row_q       <= row_d;
      idx_q       <= idx_d;
      fill_val_q  <= fill_val_d;
      fill_addr_q <= fill_addr_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      we_q        <= we_d;
      err_q       <= err_d;
      count_q     <= count_d;
    end
  end

  assign rgb_enable             = rgb_q;
  assign brightness_enable      = bright_q;
  assign ram_data_out           = wdata_q;
  assign ram_address            = waddr_q;
  assign ram_write_enable       = we_q;
  assign cmd_error              = err_q;
  assign num_commands_processed = count_q;
  assign busy                   = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_display_command_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_command_engine
//  Description : Scoreboard bench for display_command_engine. Expected RAM
//                writes are queued as commands are sent and popped as the
//                DUT issues them; enables, counters and errors are modelled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_command_engine;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [2:0]  rgb_enable;
  logic [5:0]  brightness_enable;
  logic [7:0]  ram_data_out;
  logic [9:0]  ram_address;
  logic        ram_write_enable;
  logic        busy;
  logic        cmd_error;
  logic [7:0]  num_commands_processed;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          err_cnt  = 0;
  logic        prev_err = 1'b0;
  logic [17:0] exp_q[$];
  logic [7:0]  exp_count = 8'd0;

  display_command_engine dut (
    .clk_in                 (clk_in),
    .reset                  (reset),
    .rx_data                (rx_data),
    .rx_valid               (rx_valid),
    .rgb_enable             (rgb_enable),
    .brightness_enable      (brightness_enable),
    .ram_data_out           (ram_data_out),
    .ram_address            (ram_address),
    .ram_write_enable       (ram_write_enable),
    .busy                   (busy),
    .cmd_error              (cmd_error),
    .num_commands_processed (num_commands_processed)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One byte per call: strobe for one cycle, return after the sampling edge
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_in);
    rx_valid = 1'b0;
  endtask

  // Write scoreboard and error-pulse monitor
  always @(negedge clk_in) begin
    if (!reset) begin
      if (ram_write_enable) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected_addr", {22'd0, ram_address}, 32'hFFFF_FFFF);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", {22'd0, ram_address}, {22'd0, e[17:8]});
          chk("wr_data", {24'd0, ram_data_out}, {24'd0, e[7:0]});
        end
      end
      if (cmd_error) begin
        err_cnt++;
        if (prev_err) chk("err_consecutive", {31'd0, prev_err}, 32'd0);
      end
      prev_err = cmd_error;
    end else begin
      prev_err = 1'b0;
    end
  end

  initial begin
    int e0;
    int run;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_rgb",    {29'd0, rgb_enable}, 32'h7);
    chk("rst_bright", {26'd0, brightness_enable}, 32'h3F);
    chk("rst_we",     {31'd0, ram_write_enable}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_count",  {24'd0, num_commands_processed}, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk_in);

    // Brightness command
    send_byte(8'h62);
    chk("b_busy_mid", {31'd0, busy}, 32'd1);
    send_byte(8'h15);
    exp_count++;
    chk("b_bright", {26'd0, brightness_enable}, 32'h15);
    chk("b_count",  {24'd0, num_commands_processed}, {24'd0, exp_count});
    chk("b_busy_end", {31'd0, busy}, 32'd0);

    // Row write into row 3
    for (int i = 0; i < 64; i++) exp_q.push_back({10'h0C0 + 10'(i), 8'(i)});
    send_byte(8'h4C);
    send_byte(8'h03);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    exp_count++;
    chk("L_busy_end", {31'd0, busy}, 32'd0);
    chk("L_count", {24'd0, num_commands_processed}, {24'd0, exp_count});
    repeat (2) @(negedge clk_in);
    chk("L_drained", exp_q.size(), 32'd0);

    // Fill with a byte injected mid-fill
    for (int a = 0; a < 1024; a++) exp_q.push_back({10'(a), 8'hAA});
    e0 = err_cnt;
    send_byte(8'h46);
    send_byte(8'hAA);
    run = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk_in);
      if (i == 500) begin rx_data = 8'h11; rx_valid = 1'b1; end
      if (i == 501) rx_valid = 1'b0;
      if (ram_write_enable) run++;
      else if (run > 0) break;
    end
    exp_count++;
    chk("F_run_len", run, 32'd1024);
    chk("F_err", err_cnt, e0 + 1);
    chk("F_count", {24'd0, num_commands_processed}, {24'd0, exp_count});
    chk("F_drained", exp_q.size(), 32'd0);

    // Timeout in ARG_RGB
    e0 = err_cnt;
    send_byte(8'h63);
    repeat (1990) @(negedge clk_in);
    chk("T_busy_early", {31'd0, busy}, 32'd1);
    chk("T_err_early", err_cnt, e0);
    repeat (20) @(negedge clk_in);
    chk("T_err", err_cnt, e0 + 1);
    chk("T_busy", {31'd0, busy}, 32'd0);
    chk("T_rgb", {29'd0, rgb_enable}, 32'h7);
    chk("T_count", {24'd0, num_commands_processed}, {24'd0, exp_count});
    send_byte(8'h63);
    send_byte(8'h05);
    exp_count++;
    chk("c_rgb", {29'd0, rgb_enable}, 32'h5);
    chk("c_count", {24'd0, num_commands_processed}, {24'd0, exp_count});

    // Unknown opcode
    e0 = err_cnt;
    send_byte(8'h7A);
    repeat (3) @(negedge clk_in);
    chk("U_err", err_cnt, e0 + 1);
    chk("U_count", {24'd0, num_commands_processed}, {24'd0, exp_count});
    chk("U_busy", {31'd0, busy}, 32'd0);

    // Brightness zero then restore
    send_byte(8'h62);
    send_byte(8'h00);
    exp_count++;
    chk("b0_bright", {26'd0, brightness_enable}, 32'h00);
    send_byte(8'h52);
    exp_count++;
    @(negedge clk_in);
    chk("R_bright", {26'd0, brightness_enable}, 32'h3F);
    chk("R_rgb", {29'd0, rgb_enable}, 32'h7);
    chk("R_count", {24'd0, num_commands_processed}, {24'd0, exp_count});

    // Asynchronous reset in the middle of a row write
    send_byte(8'h63);
    send_byte(8'h02);
    exp_count++;
    chk("c2_rgb", {29'd0, rgb_enable}, 32'h2);
    for (int i = 0; i < 10; i++) exp_q.push_back({10'h140 + 10'(i), 8'h30 + 8'(i)});
    send_byte(8'h4C);
    send_byte(8'h05);
    for (int i = 0; i < 10; i++) send_byte(8'h30 + 8'(i));
    @(negedge clk_in);
    chk("X_drained", exp_q.size(), 32'd0);
    #2 reset = 1'b1;
    #1;
    exp_count = 8'd0;
    chk("X_rgb",    {29'd0, rgb_enable}, 32'h7);
    chk("X_bright", {26'd0, brightness_enable}, 32'h3F);
    chk("X_we",     {31'd0, ram_write_enable}, 32'd0);
    chk("X_addr",   {22'd0, ram_address}, 32'd0);
    chk("X_data",   {24'd0, ram_data_out}, 32'd0);
    chk("X_busy",   {31'd0, busy}, 32'd0);
    chk("X_err",    {31'd0, cmd_error}, 32'd0);
    chk("X_count",  {24'd0, num_commands_processed}, 32'd0);
    @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    send_byte(8'h62);
    send_byte(8'h01);
    exp_count++;
    chk("P_bright", {26'd0, brightness_enable}, 32'h01);
    chk("P_count", {24'd0, num_commands_processed}, {24'd0, exp_count});
    repeat (2) @(negedge clk_in);
    chk("end_queue", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
`default_nettype wire
